// File: rtl/lcd_pkg.sv
// Shared LCD serial bus definitions: bus bit positions, command opcodes, FSM encoding.
// Used by both the receiver and the transmitter side of the link.
package lcd_pkg;

    localparam int CS_BIT  = 0;
    localparam int SCL_BIT = 1;
    localparam int A0_BIT  = 2;
    localparam int SI_BIT  = 3;

    localparam logic [7:0] OPC_MASK   = 8'hF0;
    localparam logic [7:0] OPC_PAGE   = 8'hB0;
    localparam logic [7:0] OPC_COL_HI = 8'h10;
    localparam logic [7:0] OPC_COL_LO = 8'h00;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    function automatic logic is_opcode(input logic [7:0] b, input logic [7:0] opc);
        return (b & OPC_MASK) == opc;
    endfunction

endpackage

// File: rtl/lcd_sync.sv
// Two-flop synchronizer for asynchronous bus lines, 2-cycle latency.
// Reset drives every bit to its idle level; no flow control.
module lcd_sync #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lcd_serial_rx.sv
// LCD serial receiver: deserializes SI on SCL rising edges while CS is low and tracks page/col.
// Bytes appear one cycle after the 8th synchronized edge; no backpressure, the host link is free-running.
module lcd_serial_rx
    import lcd_pkg::*;
#(
    parameter int COL_MAX  = 131,
    parameter int PAGE_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] lcd,
    output logic [7:0] rx_byte,
    output logic       rx_is_data,
    output logic       rx_valid,
    output logic [3:0] page,
    output logic [7:0] col,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [7:0] COL_LIM  = 8'(COL_MAX);
    localparam logic [3:0] PAGE_LIM = 4'(PAGE_MAX);

    logic [3:0] lcd_s;
    logic       cs_s, scl_s, a0_s, si_s;
    logic       scl_prev, scl_rise;
    rx_state_t  state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       byte_done, abort;

    lcd_sync #(.W(4)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (lcd),
        .q     (lcd_s)
    );

    assign cs_s     = lcd_s[CS_BIT];
    assign scl_s    = lcd_s[SCL_BIT];
    assign a0_s     = lcd_s[A0_BIT];
    assign si_s     = lcd_s[SI_BIT];
    assign scl_rise = scl_s & ~scl_prev;
    assign busy     = (state == ST_SHIFT);

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        byte_done   = 1'b0;
        abort       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cs_s)
                    state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (scl_rise) begin
                    shreg_nxt   = {shreg[6:0], si_s};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    byte_done   = (bit_cnt == 3'd7);
                end
                // An edge coincident with CS release still counts, so a just-completed byte is not an abort.
                if (cs_s) begin
                    state_nxt   = ST_IDLE;
                    abort       = (bit_cnt_nxt != 3'd0);
                    bit_cnt_nxt = 3'd0;
                    shreg_nxt   = 8'h00;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            scl_prev   <= 1'b1;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            rx_byte    <= 8'h00;
            rx_is_data <= 1'b0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            scl_prev  <= scl_s;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            rx_valid  <= byte_done;
            frame_err <= abort;
            if (byte_done) begin
                rx_byte    <= {shreg[6:0], si_s};
                rx_is_data <= a0_s;
            end
        end
    end

    // Address tracking acts on the byte while it is presented on rx_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            page <= 4'd0;
            col  <= 8'd0;
        end else if (rx_valid) begin
            if (rx_is_data) begin
                col <= (col >= COL_LIM) ? 8'd0 : col + 8'd1;
            end else if (is_opcode(rx_byte, OPC_PAGE)) begin
                if (rx_byte[3:0] <= PAGE_LIM)
                    page <= rx_byte[3:0];
            end else if (is_opcode(rx_byte, OPC_COL_HI)) begin
                col[7:4] <= rx_byte[3:0];
            end else if (is_opcode(rx_byte, OPC_COL_LO)) begin
                col[3:0] <= rx_byte[3:0];
            end
        end
    end

endmodule

// File: tb/tb_lcd_serial_rx.sv
// Directed bench for lcd_serial_rx: expected bytes queued at drive time, compared as the DUT emits them.
module tb_lcd_serial_rx;

    logic       clk;
    logic       rst_n;
    logic [3:0] lcd;
    logic [7:0] rx_byte;
    logic       rx_is_data;
    logic       rx_valid;
    logic [3:0] page;
    logic [7:0] col;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_mem[0:63];
    int         obs_cnt = 0;
    int         rd_ptr  = 0;
    int         ferr_cnt = 0;

    lcd_serial_rx #(.COL_MAX(131), .PAGE_MAX(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lcd        (lcd),
        .rx_byte    (rx_byte),
        .rx_is_data (rx_is_data),
        .rx_valid   (rx_valid),
        .page       (page),
        .col        (col),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            obs_mem[obs_cnt[5:0]] = {rx_is_data, rx_byte};
            obs_cnt = obs_cnt + 1;
        end
        if (frame_err)
            ferr_cnt = ferr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // lcd = {SI, A0, SCL, CS}
    task automatic send_bits(input logic [7:0] b, input int n, input logic a0);
        for (int i = 0; i < n; i++) begin
            lcd[3] = b[7-i];
            lcd[2] = a0;
            lcd[1] = 1'b0;
            cycles(4);
            lcd[1] = 1'b1;
            cycles(4);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic a0);
        exp_q.push_back({a0, b});
        send_bits(b, 8, a0);
    endtask

    task automatic drain(input string tag);
        int t;
        logic [8:0] e;
        t = 0;
        while ((obs_cnt - rd_ptr) < exp_q.size() && t < 200) begin
            cycles(1);
            t++;
        end
        if ((obs_cnt - rd_ptr) < exp_q.size()) begin
            checks++;
            failures++;
            $error("FAIL %s_timeout: observed=%0d bytes expected=%0d", tag, obs_cnt - rd_ptr, exp_q.size());
        end
        while (exp_q.size() > 0 && rd_ptr < obs_cnt) begin
            e = exp_q.pop_front();
            check({tag, "_byte"}, 32'(obs_mem[rd_ptr[5:0]]), 32'(e));
            rd_ptr++;
        end
        exp_q.delete();
        cycles(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_byte"}, 32'(rx_byte), 32'h00);
        check({tag, "_rx_is_data"}, 32'(rx_is_data), 32'h0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
        check({tag, "_page"}, 32'(page), 32'h0);
        check({tag, "_col"}, 32'(col), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int f0;
        rst_n = 1'b0;
        lcd   = 4'b1111;
        cycles(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cycles(3);

        // Command sequence: page 3, column 0x25
        lcd[0] = 1'b0;
        cycles(4);
        check("busy_cs_low", 32'(busy), 32'h1);
        send_byte(8'hB3, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h05, 1'b0);
        drain("cmds");
        check("page_set", 32'(page), 32'h3);
        check("col_set", 32'(col), 32'h25);

        send_byte(8'hA5, 1'b1);
        drain("data_a5");
        check("col_incr", 32'(col), 32'h26);

        // Column wrap at COL_MAX
        send_byte(8'h18, 1'b0);
        send_byte(8'h03, 1'b0);
        drain("col_131");
        check("col_131", 32'(col), 32'h83);
        send_byte(8'hFF, 1'b1);
        drain("wrap");
        check("col_wrap", 32'(col), 32'h0);
        check("page_after_wrap", 32'(page), 32'h3);

        // Partial byte aborted by CS release
        f0 = ferr_cnt;
        send_bits(8'hE7, 5, 1'b1);
        lcd[0] = 1'b1;
        cycles(10);
        check("partial_ferr", 32'(ferr_cnt - f0), 32'h1);
        check("partial_no_valid", 32'(obs_cnt - rd_ptr), 32'h0);
        check("busy_cs_high", 32'(busy), 32'h0);
        lcd[0] = 1'b0;
        cycles(4);
        send_byte(8'h3C, 1'b1);
        drain("after_abort");
        check("col_after_abort", 32'(col), 32'h1);

        // Out-of-range page command
        send_byte(8'hB9, 1'b0);
        drain("page_b9");
        check("page_ignored", 32'(page), 32'h3);

        // Column written above COL_MAX wraps on next data byte
        send_byte(8'h19, 1'b0);
        send_byte(8'h00, 1'b0);
        drain("col_90");
        check("col_above_max", 32'(col), 32'h90);
        send_byte(8'h11, 1'b1);
        drain("wrap_above");
        check("col_wrap_above", 32'(col), 32'h0);

        // 8th edge coincident with CS release
        f0 = ferr_cnt;
        exp_q.push_back({1'b1, 8'h5A});
        send_bits(8'h5A, 7, 1'b1);
        lcd[3] = 1'b0;
        lcd[1] = 1'b0;
        cycles(4);
        lcd[1] = 1'b1;
        lcd[0] = 1'b1;
        cycles(10);
        drain("edge_cs");
        check("edge_cs_no_ferr", 32'(ferr_cnt - f0), 32'h0);
        check("col_edge_cs", 32'(col), 32'h1);

        // Reset in the middle of a byte
        lcd[0] = 1'b0;
        cycles(4);
        f0 = ferr_cnt;
        send_bits(8'hC3, 4, 1'b1);
        rst_n = 1'b0;
        cycles(2);
        check_reset_outputs("mid_reset");
        lcd = 4'b1111;
        cycles(2);
        rst_n = 1'b1;
        cycles(4);
        check("reset_no_ferr", 32'(ferr_cnt - f0), 32'h0);
        check("reset_no_valid", 32'(obs_cnt - rd_ptr), 32'h0);
        lcd[0] = 1'b0;
        cycles(4);
        send_byte(8'h81, 1'b0);
        drain("after_reset");
        check("page_after_reset", 32'(page), 32'h0);
        check("col_after_reset", 32'(col), 32'h0);
        lcd[0] = 1'b1;
        cycles(10);
        check("ferr_total", 32'(ferr_cnt), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
